nco_phase_gen: RTL and testbench



---
 rtl/nco_phase_gen.sv | 128 ++++++++++++
 tb/tb_nco_phase_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_phase_gen.sv
// Phase accumulator NCO. It ticks at a programmable sample rate, folds each phase into
// the CORDIC range of +/-90 degrees, and emits the folded angle over a valid/ready handshake.
module nco_phase_gen #(
    parameter int PHASE_WIDTH = 32,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic                   enable,
    input  logic                   phase_clr,
    input  logic [PHASE_WIDTH-1:0] fcw_in,
    input  logic                   fcw_load,
    input  logic [DIV_WIDTH-1:0]   div_in,
    output logic [PHASE_WIDTH-1:0] angle_out,
    output logic [1:0]             quadrant_out,
    output logic                   negate_out,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic                   overrun,
    input  logic                   overrun_clr
);

    localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] fcw_act_q, fcw_act_d;
    logic [PHASE_WIDTH-1:0] fcw_pend_q, fcw_pend_d;
    logic                   pend_q, pend_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PHASE_WIDTH-1:0] angle_q, angle_d;
    logic [1:0]             quad_q, quad_d;
    logic                   neg_q, neg_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d;

    logic [DIV_WIDTH-1:0]   div_last;
    logic                   tick;
    logic                   fold_neg;

    // A divider of 0 behaves like 1. Using >= rather than == makes a shrunken divider
    // tick on the next enabled cycle.
    assign div_last = (div_in == '0) ? '0 : div_in - CNT_ONE;
    assign tick     = enable && !phase_clr && (cnt_q >= div_last);
    assign fold_neg = phase_q[PHASE_WIDTH-1] ^ phase_q[PHASE_WIDTH-2];

    always_comb begin
        phase_d    = phase_q;
        fcw_act_d  = fcw_act_q;
        fcw_pend_d = fcw_pend_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        angle_d    = angle_q;
        quad_d     = quad_q;
        neg_d      = neg_q;
        valid_d    = valid_q;
        ovr_d      = ovr_q;

        if (phase_clr) begin
            phase_d = '0;
            cnt_d   = '0;
        end else if (tick) begin
            phase_d = phase_q + fcw_act_q;
            cnt_d   = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        // The sample leaves with the pre-increment phase. Quadrants 1 and 2 are rotated by
        // 180 degrees, and the waveform stage undoes that rotation by negating.
        if (tick) begin
            quad_d  = phase_q[PHASE_WIDTH-1:PHASE_WIDTH-2];
            neg_d   = fold_neg;
            angle_d = {phase_q[PHASE_WIDTH-1] ^ fold_neg, phase_q[PHASE_WIDTH-2:0]};
            valid_d = 1'b1;
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end

        if (tick && valid_q && !sample_ready) begin
            ovr_d = 1'b1;
        end else if (overrun_clr) begin
            ovr_d = 1'b0;
        end

        // A pending word is promoted at a tick. A load on that same cycle waits for the next tick.
        if (tick && pend_q) begin
            fcw_act_d = fcw_pend_q;
            pend_d    = 1'b0;
        end
        if (fcw_load) begin
            fcw_pend_d = fcw_in;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            phase_q    <= '0;
            fcw_act_q  <= '0;
            fcw_pend_q <= '0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            angle_q    <= '0;
            quad_q     <= '0;
            neg_q      <= 1'b0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            fcw_act_q  <= fcw_act_d;
            fcw_pend_q <= fcw_pend_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            angle_q    <= angle_d;
            quad_q     <= quad_d;
            neg_q      <= neg_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    assign angle_out    = angle_q;
    assign quadrant_out = quad_q;
    assign negate_out   = neg_q;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_nco_phase_gen.sv
// Bench for nco_phase_gen. It runs a fold table, directed sequences for the multi-cycle
// corners, and random stimulus checked every cycle against a lockstep reference model.
module tb_nco_phase_gen;
    localparam int PW = 32;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_in = 1'b0;
    logic          enable = 1'b0, phase_clr = 1'b0, fcw_load = 1'b0;
    logic          sample_ready = 1'b0, overrun_clr = 1'b0;
    logic [PW-1:0] fcw_in = '0;
    logic [DW-1:0] div_in = '0;
    logic [PW-1:0] angle_out;
    logic [1:0]    quadrant_out;
    logic          negate_out, sample_valid, overrun;

    nco_phase_gen #(.PHASE_WIDTH(PW), .DIV_WIDTH(DW)) dut (
        .clk(clk), .rst_in(rst_in), .enable(enable), .phase_clr(phase_clr),
        .fcw_in(fcw_in), .fcw_load(fcw_load), .div_in(div_in),
        .angle_out(angle_out), .quadrant_out(quadrant_out), .negate_out(negate_out),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The reference model tracks the phase as plain modular arithmetic. The fold is applied
    // as a 180-degree rotation of the phase.
    bit [31:0] m_phase, m_act, m_pval, m_angle;
    bit        m_pend, m_valid, m_neg, m_ovr;
    bit [1:0]  m_quad;
    int        m_cnt;

    task automatic m_reset();
        m_phase = 0; m_act = 0; m_pval = 0; m_angle = 0;
        m_pend = 0; m_valid = 0; m_neg = 0; m_ovr = 0; m_quad = 0; m_cnt = 0;
    endtask

    task automatic m_edge();
        int period;
        bit tick;
        period = (div_in == 0) ? 1 : int'(div_in);
        tick   = enable && !phase_clr && (m_cnt >= period - 1);
        if (tick && m_valid && !sample_ready) m_ovr = 1;
        else if (overrun_clr) m_ovr = 0;
        if (tick) begin
            m_quad  = 2'(m_phase / 32'h4000_0000);
            m_neg   = (m_quad == 1) || (m_quad == 2);
            m_angle = m_neg ? m_phase + 32'h8000_0000 : m_phase;
            m_valid = 1;
        end else if (m_valid && sample_ready) begin
            m_valid = 0;
        end
        if (phase_clr) begin
            m_phase = 0; m_cnt = 0;
        end else if (tick) begin
            m_phase = m_phase + m_act; m_cnt = 0;
        end else if (enable) begin
            m_cnt++;
        end
        if (tick && m_pend) begin m_act = m_pval; m_pend = 0; end
        if (fcw_load) begin m_pval = fcw_in; m_pend = 1; end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".valid"}, sample_valid, m_valid);
        chk({tag, ".angle"}, angle_out, m_angle);
        chk({tag, ".quad"}, quadrant_out, m_quad);
        chk({tag, ".neg"}, negate_out, m_neg);
        chk({tag, ".ovr"}, overrun, m_ovr);
    endtask

    task automatic cyc();
        @(posedge clk);
        m_edge();
        #1;
        cmp_all("model");
    endtask

    // Asserts reset between edges and checks the outputs before any edge arrives.
    task automatic do_reset();
        #2;
        rst_in = 1'b1;
        m_reset();
        #1;
        chk("async_rst.valid", sample_valid, 0);
        chk("async_rst.angle", angle_out, 0);
        chk("async_rst.ovr", overrun, 0);
        cmp_all("rst");
        @(negedge clk);
        rst_in = 1'b0;
        enable = 0; phase_clr = 0; fcw_load = 0; overrun_clr = 0;
    endtask

    typedef struct {
        logic [31:0] ph;
        logic [31:0] ang;
        logic [1:0]  q;
        logic        n;
    } fold_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        fold_t ft[10];
        logic [31:0] wa[6];
        logic        wn[6];
        ft[0] = '{32'h0000_0000, 32'h0000_0000, 2'd0, 1'b0};
        ft[1] = '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 2'd0, 1'b0};
        ft[2] = '{32'h4000_0000, 32'hC000_0000, 2'd1, 1'b1};
        ft[3] = '{32'h5000_0000, 32'hD000_0000, 2'd1, 1'b1};
        ft[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'd1, 1'b1};
        ft[5] = '{32'h8000_0000, 32'h0000_0000, 2'd2, 1'b1};
        ft[6] = '{32'hBFFF_FFFF, 32'h3FFF_FFFF, 2'd2, 1'b1};
        ft[7] = '{32'hC000_0000, 32'hC000_0000, 2'd3, 1'b0};
        ft[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd3, 1'b0};
        ft[9] = '{32'h1234_5678, 32'h1234_5678, 2'd0, 1'b0};
        wa = '{32'h0, 32'h0, 32'hC000_0000, 32'h0, 32'hC000_0000, 32'h0};
        wn = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        m_reset();
        #1 rst_in = 1'b1;
        #2;
        chk("reset.valid", sample_valid, 0);
        chk("reset.angle", angle_out, 0);
        chk("reset.quad", quadrant_out, 0);
        chk("reset.neg", negate_out, 0);
        chk("reset.ovr", overrun, 0);
        @(negedge clk);
        rst_in = 1'b0;

        // Fold table: the third sample after loading FCW=p carries phase p.
        foreach (ft[i]) begin
            do_reset();
            fcw_load = 1; fcw_in = ft[i].ph; div_in = 1; sample_ready = 1;
            cyc();
            fcw_load = 0; enable = 1;
            cyc(); cyc(); cyc();
            chk($sformatf("fold%0d.angle", i), angle_out, ft[i].ang);
            chk($sformatf("fold%0d.quad", i), quadrant_out, ft[i].q);
            chk($sformatf("fold%0d.neg", i), negate_out, ft[i].n);
        end

        // Quarter-turn steps that wrap through 360 degrees.
        do_reset();
        fcw_load = 1; fcw_in = 32'h4000_0000; div_in = 1; sample_ready = 1;
        cyc();
        fcw_load = 0; enable = 1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk($sformatf("wrap%0d.angle", k), angle_out, wa[k]);
            chk($sformatf("wrap%0d.neg", k), negate_out, wn[k]);
        end

        // Divider of 4 with enable dropped mid-count, followed by divider 0.
        do_reset();
        div_in = 4; sample_ready = 1; enable = 1;
        cyc(); cyc();
        enable = 0;
        cyc(); cyc(); cyc();
        chk("div4.frozen", sample_valid, 0);
        enable = 1;
        cyc();
        chk("div4.e3", sample_valid, 0);
        cyc();
        chk("div4.e4", sample_valid, 1);
        cyc();
        chk("div4.e5", sample_valid, 0);
        div_in = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("div0.%0d", k), sample_valid, 1);
        end

        // Stalled consumer: hold, overwrite, set-wins clear, then a plain clear.
        do_reset();
        fcw_load = 1; fcw_in = 32'h1000_0000; div_in = 2; sample_ready = 0;
        cyc();
        fcw_load = 0; enable = 1;
        cyc(); cyc();
        chk("ovr.first_valid", sample_valid, 1);
        chk("ovr.first_ovr", overrun, 0);
        cyc();
        chk("ovr.hold_angle", angle_out, 0);
        chk("ovr.hold_ovr", overrun, 0);
        cyc();
        chk("ovr.set", overrun, 1);
        cyc();
        overrun_clr = 1;
        cyc();
        chk("ovr.set_wins", overrun, 1);
        chk("ovr.new_angle", angle_out, 32'h1000_0000);
        cyc();
        chk("ovr.cleared", overrun, 0);
        overrun_clr = 0;

        // Retune while running: the old step applies once more before the new one takes over.
        do_reset();
        fcw_load = 1; fcw_in = 32'h0100_0000; div_in = 1; sample_ready = 1;
        cyc();
        fcw_load = 0; enable = 1;
        cyc(); cyc(); cyc();
        chk("retune.pre", angle_out, 32'h0100_0000);
        fcw_load = 1; fcw_in = 32'h0200_0000;
        cyc();
        chk("retune.s0", angle_out, 32'h0200_0000);
        fcw_load = 0;
        cyc(); chk("retune.s1", angle_out, 32'h0300_0000);
        cyc(); chk("retune.s2", angle_out, 32'h0400_0000);
        cyc(); chk("retune.s3", angle_out, 32'h0600_0000);

        // phase_clr on a tick cycle: no sample is produced, and the next sample is phase 0.
        phase_clr = 1;
        cyc();
        chk("pclr.no_sample", sample_valid, 0);
        phase_clr = 0;
        cyc();
        chk("pclr.valid", sample_valid, 1);
        chk("pclr.angle", angle_out, 0);

        // Reset arrives while a sample is pending.
        sample_ready = 0;
        chk("midrst.pre_valid", sample_valid, 1);
        do_reset();

        // Randomized traffic against the model.
        div_in = 3;
        for (int k = 0; k < 3000; k++) begin
            enable       = ($urandom_range(0, 9) != 0);
            phase_clr    = ($urandom_range(0, 59) == 0);
            fcw_load     = ($urandom_range(0, 19) == 0);
            fcw_in       = $urandom;
            sample_ready = ($urandom_range(0, 3) != 0);
            overrun_clr  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 39) == 0) div_in = DW'($urandom_range(0, 6));
            if ($urandom_range(0, 599) == 0) do_reset();
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
